mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle successor to the single-cycle ID control unit. It keeps the same opcode set, ALUOp and load_mode encodings, and drives the same datapath control names. Instead of decoding per cycle, it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared, handshaked memory port. It adds a memory-timeout fault, illegal-opcode trapping and a retired-instruction counter. It sits between the IR and the multi-cycle datapath.

## Interface
- ALUOP_W, 3: ALUOp width (min 3).
- MEM_TIMEOUT, 16: max wait cycles for mem_ack; 0 disables the timeout.
- CNT_W, 32: retired-instruction counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- OP_CODE  in  6  IR[31:26]; valid from DECODE until the next fetch ack.
- mem_ack  in  1  memory completes the current request this cycle.
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch  out  1 each  datapath controls.
- ALUOp  out  ALUOP_W  000 add, 001 sub, 010 R-funct, 011 and, 100 or.
- load_mode  out  2  00 word, 01 half signed, 10 half unsigned.
- IorD  out  1  0 = address from PC, 1 = address from ALUOut.
- mem_req  out  1  memory request; held high until mem_ack.
- pc_write, ir_write  out  1  PC+4 / IR load strobes.
- fault  out  1  sticky error flag.
- retired_count  out  CNT_W  completed instructions.

## Operation
- Opcodes: R 000000, addi 001000, lw 100111, lh 100001, lhu 100101, sw 101011, beq 000100, andi 001100, ori 001101. Any other opcode is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
- FETCH: mem_req=1, MemRead=1, IorD=0; pc_write=ir_write=mem_ack. On mem_ack, go to DECODE; otherwise stay.
- DECODE: all controls 0. Latch OP_CODE into opcode_q. Illegal opcode goes to FAULT; otherwise go to EXEC.
- EXEC: ALUSrc=1 for all except R and beq.
- EXEC ALUOp per opcode: add for addi/loads/sw, sub for beq, R-funct for R, and for andi, or for ori.
- EXEC Branch: 1 for beq; beq then returns to FETCH (retires).
- EXEC next state: loads and sw go to MEM; all others go to WB.
- MEM: mem_req=1, IorD=1. Loads: MemRead=1 and load_mode driven. sw: MemWrite=1. On mem_ack, loads go to WB; sw returns to FETCH and retires.
- WB: RegWrite=1; RegDst=1 only for R; MemToReg=1 and load_mode only for loads. Then return to FETCH and retire.
- Any control not listed for a state is 0.
- Retire: retired_count increments by 1 on each transition into FETCH from EXEC/MEM/WB. It wraps modulo 2^CNT_W.
- Wait counter: reset to 0 on entry to FETCH/MEM; increments each cycle mem_req=1 and mem_ack=0.
- Timeout: if MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with no ack, go to FAULT next cycle. If mem_ack arrives in that same cycle, the ack wins.
- FAULT: fault=1, all other controls 0, counter frozen. Exit only by reset.

## Timing
- Reset (async assert): state=FETCH, opcode_q=0, wait counter=0, retired_count=0, fault=0.
- During reset all outputs are 0. The first cycle after release is FETCH with mem_req=1.
- Outputs are decoded combinationally from state/opcode_q. pc_write and ir_write also depend on mem_ack (same-cycle).
- Cycles with zero-wait memory: beq 3, R/addi/andi/ori/sw 4, loads 5.
- Each wait cycle adds 1.
- Reset mid-request drops mem_req asynchronously; the pending instruction is abandoned and not counted.

## Structure
- Shared package mc_ctrl_pkg: opcode localparams, ALUOp codes, load_mode codes, state enum (3-bit).
- ID_Control_Unit's opcode decode is reused as sub-module opcode_decoder. It is purely combinational: OP_CODE in; class, ALUOp, ALUSrc and load_mode out.
- The FSM, wait counter and retire counter live in mc_control_unit.

## Test plan
- R-type, mem_ack tied 1: states FETCH→DECODE→EXEC(ALUOp=010)→WB(RegDst=1, RegWrite=1) → 4 cycles; retired_count=1.
- lh with mem_ack delayed 2 cycles in MEM: MEM lasts 3 cycles with IorD=1, MemRead=1, load_mode=01; WB has MemToReg=1; total 7 cycles.
- beq then sw back to back: beq shows Branch=1 and ALUOp=001 in EXEC; sw shows MemWrite=1 in MEM; retired_count=2 after 7 cycles.
- Opcode 111111 → FAULT after DECODE; fault stays 1 for 20 cycles and all controls stay 0. After rst_n pulse: fault=0, mem_req=1.
- MEM_TIMEOUT=4, mem_ack never asserted in FETCH → fault=1 on cycle 5. Repeat with ack on cycle 4 → DECODE, no fault.
- CNT_W=2: retire 5 instructions → retired_count=1. Assert rst_n low mid-MEM → mem_req=0 immediately; count=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALUOp,
// load_mode, FSM states and decoded instruction classes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] LM_WORD   = 2'b00;
  localparam logic [1:0] LM_HALF_S = 2'b01;
  localparam logic [1:0] LM_HALF_U = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_R       = 3'd1,
    CLS_ALUI    = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5
  } iclass_e;

endpackage

// File: rtl/mc_control_unit_opcode_decoder.sv
// Combinational opcode decode carried over from the single-cycle control
// unit: instruction class plus the EXEC-stage ALU controls and load_mode.
module opcode_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code_i,
  output logic [2:0] iclass_o,
  output logic [2:0] aluop_o,
  output logic       alusrc_o,
  output logic [1:0] load_mode_o
);

  always_comb begin
    iclass_o    = CLS_ILLEGAL;
    aluop_o     = ALU_ADD;
    alusrc_o    = 1'b0;
    load_mode_o = LM_WORD;
    case (op_code_i)
      OP_R:    begin iclass_o = CLS_R;      aluop_o = ALU_FUNCT; end
      OP_ADDI: begin iclass_o = CLS_ALUI;   alusrc_o = 1'b1; end
      OP_ANDI: begin iclass_o = CLS_ALUI;   alusrc_o = 1'b1; aluop_o = ALU_AND; end
      OP_ORI:  begin iclass_o = CLS_ALUI;   alusrc_o = 1'b1; aluop_o = ALU_OR; end
      OP_LW:   begin iclass_o = CLS_LOAD;   alusrc_o = 1'b1; end
      OP_LH:   begin iclass_o = CLS_LOAD;   alusrc_o = 1'b1; load_mode_o = LM_HALF_S; end
      OP_LHU:  begin iclass_o = CLS_LOAD;   alusrc_o = 1'b1; load_mode_o = LM_HALF_U; end
      OP_SW:   begin iclass_o = CLS_STORE;  alusrc_o = 1'b1; end
      OP_BEQ:  begin iclass_o = CLS_BRANCH; aluop_o = ALU_SUB; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// handshaked memory port, with memory timeout, illegal-opcode trap and retire count.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OP_CODE,
  input  logic               mem_ack,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemToReg,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         load_mode,
  output logic               IorD,
  output logic               mem_req,
  output logic               pc_write,
  output logic               ir_write,
  output logic               fault,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [5:0]          opcode_q, opcode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [5:0] dec_op;
  logic [2:0] dec_cls_raw;
  logic [2:0] dec_aluop;
  logic       dec_alusrc;
  logic [1:0] dec_lm;
  iclass_e    dec_cls;
  logic       waiting;
  logic       timeout;
  logic       retire;

  // In DECODE the opcode has not been latched yet, so decode the live IR field.
  assign dec_op = (state_q == ST_DECODE) ? OP_CODE : opcode_q;

  opcode_decoder u_dec (
    .op_code_i   (dec_op),
    .iclass_o    (dec_cls_raw),
    .aluop_o     (dec_aluop),
    .alusrc_o    (dec_alusrc),
    .load_mode_o (dec_lm)
  );

  assign dec_cls = iclass_e'(dec_cls_raw);
  assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack)      state_d = ST_DECODE;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        opcode_d = OP_CODE;
        state_d  = (dec_cls == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        case (dec_cls)
          CLS_BRANCH:          state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ack)      state_d = (dec_cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_WB:    state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign retire = (state_d == ST_FETCH) &&
                  ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));

  always_comb begin
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    wait_d    = wait_q;
    // The counter restarts on entry to a memory state and freezes on leaving it.
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)))
      wait_d = '0;
    else if (waiting && (state_d == state_q))
      wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Controls are gated by rst_n so a reset mid-request drops them at once.
  always_comb begin
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    MemToReg  = 1'b0;
    Branch    = 1'b0;
    ALUOp     = '0;
    load_mode = LM_WORD;
    IorD      = 1'b0;
    mem_req   = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    fault     = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          MemRead  = 1'b1;
          pc_write = mem_ack;
          ir_write = mem_ack;
        end
        ST_EXEC: begin
          ALUSrc = dec_alusrc;
          ALUOp  = ALUOP_W'(dec_aluop);
          Branch = (dec_cls == CLS_BRANCH);
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemRead  = (dec_cls == CLS_LOAD);
          MemWrite = (dec_cls == CLS_STORE);
          if (dec_cls == CLS_LOAD) load_mode = dec_lm;
        end
        ST_WB: begin
          RegWrite = 1'b1;
          RegDst   = (dec_cls == CLS_R);
          MemToReg = (dec_cls == CLS_LOAD);
          if (dec_cls == CLS_LOAD) load_mode = dec_lm;
        end
        ST_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired_count = retired_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expected control vectors are
// queued by the stimulus process and checked by an independent monitor.
module tb_mc_control_unit;

  localparam int ALUOP_W     = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;

  // Expected-vector bit masks: {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,
  // Branch,ALUOp[2:0],load_mode[1:0],IorD,mem_req,pc_write,ir_write,fault}
  localparam logic [16:0] E_RD   = 17'h10000;
  localparam logic [16:0] E_RW   = 17'h08000;
  localparam logic [16:0] E_AS   = 17'h04000;
  localparam logic [16:0] E_MW   = 17'h02000;
  localparam logic [16:0] E_MR   = 17'h01000;
  localparam logic [16:0] E_M2R  = 17'h00800;
  localparam logic [16:0] E_BR   = 17'h00400;
  localparam logic [16:0] E_IORD = 17'h00010;
  localparam logic [16:0] E_MQ   = 17'h00008;
  localparam logic [16:0] E_PCW  = 17'h00004;
  localparam logic [16:0] E_IRW  = 17'h00002;
  localparam logic [16:0] E_FLT  = 17'h00001;
  localparam logic [16:0] E_NONE = 17'h00000;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_LH  = 6'b100001;
  localparam logic [5:0] O_LW  = 6'b100111;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100;
  localparam logic [5:0] O_BAD = 6'b111111;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [5:0]         OP_CODE = '0;
  logic               mem_ack = 1'b0;
  logic               RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         load_mode;
  logic               IorD, mem_req, pc_write, ir_write, fault;
  logic [CNT_W-1:0]   retired_count;

  typedef struct {
    string       name;
    logic [16:0] ev;
    logic [1:0]  ec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [16:0] act;

  mc_control_unit #(
    .ALUOP_W     (ALUOP_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .OP_CODE       (OP_CODE),
    .mem_ack       (mem_ack),
    .RegDst        (RegDst),
    .RegWrite      (RegWrite),
    .ALUSrc        (ALUSrc),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .MemToReg      (MemToReg),
    .Branch        (Branch),
    .ALUOp         (ALUOp),
    .load_mode     (load_mode),
    .IorD          (IorD),
    .mem_req       (mem_req),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .fault         (fault),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  assign act = {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch,
                ALUOp, load_mode, IorD, mem_req, pc_write, ir_write, fault};

  function automatic logic [16:0] aop(input logic [2:0] a);
    aop = 17'(a) << 7;
  endfunction

  function automatic logic [16:0] lm(input logic [1:0] l);
    lm = 17'(l) << 5;
  endfunction

  task automatic step(input logic rstn, input logic ack, input logic [5:0] op,
                      input string nm, input logic [16:0] ev, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rstn;
    mem_ack = ack;
    OP_CODE = op;
    e.name = nm;
    e.ev   = ev;
    e.ec   = ec;
    q.push_back(e);
  endtask

  // Monitor: compares whatever the stimulus queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (act !== e.ev || retired_count !== e.ec) begin
          n_fail++;
          $display("FAIL %s: ctrl=%05h cnt=%0d, required ctrl=%05h cnt=%0d",
                   e.name, act, retired_count, e.ev, e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then R-type with zero-wait memory.
    step(1'b0, 1'b1, O_R, "reset", E_NONE, 2'd0);
    step(1'b1, 1'b1, O_R, "r_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'd0);
    step(1'b1, 1'b1, O_R, "r_decode", E_NONE, 2'd0);
    step(1'b1, 1'b1, O_R, "r_exec", aop(3'b010), 2'd0);
    step(1'b1, 1'b1, O_R, "r_wb", E_RD | E_RW, 2'd0);

    // lh with two wait cycles in MEM.
    step(1'b1, 1'b1, O_LH, "lh_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'd1);
    step(1'b1, 1'b1, O_LH, "lh_decode", E_NONE, 2'd1);
    step(1'b1, 1'b1, O_LH, "lh_exec", E_AS | aop(3'b000), 2'd1);
    step(1'b1, 1'b0, O_LH, "lh_mem_w1", E_IORD | E_MQ | E_MR | lm(2'b01), 2'd1);
    step(1'b1, 1'b0, O_LH, "lh_mem_w2", E_IORD | E_MQ | E_MR | lm(2'b01), 2'd1);
    step(1'b1, 1'b1, O_LH, "lh_mem_ack", E_IORD | E_MQ | E_MR | lm(2'b01), 2'd1);
    step(1'b1, 1'b1, O_LH, "lh_wb", E_RW | E_M2R | lm(2'b01), 2'd1);

    // beq then sw back to back.
    step(1'b1, 1'b1, O_BEQ, "beq_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'd2);
    step(1'b1, 1'b1, O_BEQ, "beq_decode", E_NONE, 2'd2);
    step(1'b1, 1'b1, O_BEQ, "beq_exec", E_BR | aop(3'b001), 2'd2);
    step(1'b1, 1'b1, O_SW, "sw_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'd3);
    step(1'b1, 1'b1, O_SW, "sw_decode", E_NONE, 2'd3);
    step(1'b1, 1'b1, O_SW, "sw_exec", E_AS | aop(3'b000), 2'd3);
    step(1'b1, 1'b1, O_SW, "sw_mem", E_IORD | E_MQ | E_MW, 2'd3);

    // Illegal opcode traps and holds; count wrapped to 0 (4 mod 4).
    step(1'b1, 1'b1, O_BAD, "ill_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'd0);
    step(1'b1, 1'b1, O_BAD, "ill_decode", E_NONE, 2'd0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'(i % 2), O_BAD, "fault_hold", E_FLT, 2'd0);

    // Reset pulse clears the fault; then fetch timeout with no ack.
    step(1'b0, 1'b0, O_R, "rst_pulse", E_NONE, 2'd0);
    step(1'b1, 1'b0, O_R, "tmo_c1", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "tmo_c2", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "tmo_c3", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "tmo_c4", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "tmo_c5_fault", E_FLT, 2'd0);
    step(1'b1, 1'b1, O_R, "tmo_c6_fault", E_FLT, 2'd0);

    // Ack in the last allowed cycle wins over the timeout.
    step(1'b0, 1'b0, O_R, "rst_pulse2", E_NONE, 2'd0);
    step(1'b1, 1'b0, O_R, "late_c1", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "late_c2", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b0, O_R, "late_c3", E_MQ | E_MR, 2'd0);
    step(1'b1, 1'b1, O_R, "late_c4_ack", E_MQ | E_MR | E_PCW | E_IRW, 2'd0);
    step(1'b1, 1'b1, O_R, "late_decode", E_NONE, 2'd0);
    step(1'b1, 1'b1, O_R, "late_exec", aop(3'b010), 2'd0);
    step(1'b1, 1'b1, O_R, "late_wb", E_RD | E_RW, 2'd0);

    // Four more beq: five retired in total wraps the 2-bit counter to 1.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, O_BEQ, "wrap_fetch", E_MQ | E_MR | E_PCW | E_IRW, 2'(k + 1));
      step(1'b1, 1'b1, O_BEQ, "wrap_decode", E_NONE, 2'(k + 1));
      step(1'b1, 1'b1, O_BEQ, "wrap_exec", E_BR | aop(3'b001), 2'(k + 1));
    end

    // lw abandoned by reset in the middle of MEM.
    step(1'b1, 1'b1, O_LW, "lw_fetch_cnt5", E_MQ | E_MR | E_PCW | E_IRW, 2'd1);
    step(1'b1, 1'b1, O_LW, "lw_decode", E_NONE, 2'd1);
    step(1'b1, 1'b1, O_LW, "lw_exec", E_AS | aop(3'b000), 2'd1);
    step(1'b1, 1'b0, O_LW, "lw_mem", E_IORD | E_MQ | E_MR | lm(2'b00), 2'd1);
    step(1'b0, 1'b0, O_LW, "lw_mem_reset", E_NONE, 2'd0);
    step(1'b1, 1'b0, O_LW, "post_reset_fetch", E_MQ | E_MR, 2'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
